// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner: snapshots num1..num4 once per frame and
// scans them onto a shared active-low segment bus. Define SEG_SCAN_BLANK_EN for anti-ghost blanking.
module seg_scan #(
  parameter int DIV   = 50000,
  parameter int BLANK = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] num1,
  input  logic [6:0] num2,
  input  logic [6:0] num3,
  input  logic [6:0] num4,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       frame
);

  localparam int            CW      = $clog2(DIV);
  localparam logic [CW-1:0] LAST    = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_C = CW'(BLANK);

`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic [CW-1:0] div_cnt;
  logic [1:0]    slot;
  logic [6:0]    sh [4];

  logic       wrap;
  logic       snap;
  logic       blank;
  logic [3:0] an_d;
  logic [6:0] seg_d;

  assign wrap  = (div_cnt == LAST);
  assign snap  = (div_cnt == '0) && (slot == 2'd0);
  assign blank = BLANK_EN && (BLANK > 0) && (div_cnt < BLANK_C);

  // The snapshot cycle shows slot 0 straight from num1, since sh[0] only loads on this same edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    an_d  = 4'b1111;
    seg_d = 7'h7F;
    if (!blank) begin
      an_d  = ~(4'b1000 >> slot);
      seg_d = snap ? num1 : sh[slot];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      slot    <= 2'd0;
      // NOTE: the shadow array is reset too, so the display is dark rather than random before the first frame.
      for (int i = 0; i < 4; i++) sh[i] <= 7'h7F;
      an      <= 4'b1111;
      seg     <= 7'h7F;
      frame   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
      div_cnt <= wrap ? '0 : div_cnt + 1'b1;
      if (wrap) slot <= slot + 2'd1;
      if (snap) begin
        sh[0] <= num1;
        sh[1] <= num2;
        sh[2] <= num3;
        sh[3] <= num4;
      end
      an    <= an_d;
      seg   <= seg_d;
      frame <= snap;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan: three instances (DIV 8/5/2) run side by side against a
// frame-position reference model; covers reset, tear-free snapshots, cadence and async mid-slot reset.
module tb_seg_scan;

  localparam int N = 3;
  localparam int DIVS [N] = '{8, 5, 2};
  localparam int BLKS [N] = '{2, 2, 1};
`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_ON = 1'b1;
`else
  localparam bit BLANK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] num [4];
  logic [3:0] an_w [N];
  logic [6:0] seg_w [N];
  logic       frame_w [N];

  int cyc [N];
  logic [6:0] snapm [N][4];
  logic [3:0] exp_an [N];
  logic [6:0] exp_seg [N];
  logic       exp_frame [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_scan #(.DIV(8), .BLANK(2)) u_a (
    .clk(clk), .rst(rst), .num1(num[0]), .num2(num[1]), .num3(num[2]), .num4(num[3]),
    .an(an_w[0]), .seg(seg_w[0]), .frame(frame_w[0]));
  seg_scan #(.DIV(5), .BLANK(2)) u_b (
    .clk(clk), .rst(rst), .num1(num[0]), .num2(num[1]), .num3(num[2]), .num4(num[3]),
    .an(an_w[1]), .seg(seg_w[1]), .frame(frame_w[1]));
  seg_scan #(.DIV(2), .BLANK(1)) u_c (
    .clk(clk), .rst(rst), .num1(num[0]), .num2(num[1]), .num3(num[2]), .num4(num[3]),
    .an(an_w[2]), .seg(seg_w[2]), .frame(frame_w[2]));

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      cyc[d] = 0;
      for (int s = 0; s < 4; s++) snapm[d][s] = 7'h7F;
      exp_an[d]    = 4'hF;
      exp_seg[d]   = 7'h7F;
      exp_frame[d] = 1'b0;
    end
  endtask

  // Position within the frame decides everything: which digit, whether dark, whether a snapshot.
  task automatic model_edge();
    int pos, slot, off;
    bit dark;
    logic [3:0] lit;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < N; d++) begin
      pos  = cyc[d] % (4 * DIVS[d]);
      slot = pos / DIVS[d];
      off  = pos % DIVS[d];
      if (pos == 0) for (int s = 0; s < 4; s++) snapm[d][s] = num[s];
      dark = BLANK_ON && (off < BLKS[d]);
      lit  = 4'b1000 >> slot;
      exp_frame[d] = (pos == 0);
      exp_an[d]    = dark ? 4'hF : ~lit;
      exp_seg[d]   = dark ? 7'h7F : snapm[d][slot];
      cyc[d]++;
    end
  endtask

  task automatic check_all(input string tag);
    for (int d = 0; d < N; d++) begin
      chk({tag, "_an"}, d, 32'(an_w[d]), 32'(exp_an[d]));
      chk({tag, "_seg"}, d, 32'(seg_w[d]), 32'(exp_seg[d]));
      chk({tag, "_frame"}, d, 32'(frame_w[d]), 32'(exp_frame[d]));
      chk({tag, "_one_digit"}, d, 32'($countones(~an_w[d]) <= 1), 32'(1));
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic randomize_nums();
    for (int s = 0; s < 4; s++) num[s] = 7'($urandom_range(0, 127));
  endtask

  int pulses;
  int last_pulse;

  initial begin
    num[0] = 7'h12; num[1] = 7'h79; num[2] = 7'h12; num[3] = 7'h40;

    // Reset before any clock edge: outputs must settle asynchronously.
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_async");
    tick("reset_hold");
    tick("reset_hold");
    #3 rst = 1'b0;

    // First frames with the directed patterns; num3 changes during slot 1 of the first frame.
    for (int i = 0; i < 72; i++) begin
      tick("first_frames");
      if (i == 10) #2 num[2] = 7'h30;
    end

    // Frame cadence on the DIV=5 instance over 200 cycles from a fresh reset.
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid_run");
    tick("reset_hold");
    #3 rst = 1'b0;
    pulses = 0;
    last_pulse = -1;
    for (int i = 0; i < 200; i++) begin
      if (i % 7 == 3) randomize_nums();
      tick("cadence");
      if (frame_w[1]) begin
        if (last_pulse >= 0) chk("frame_gap", 1, 32'(i - last_pulse), 32'(20));
        last_pulse = i;
        pulses++;
      end
    end
    chk("frame_count", 1, 32'(pulses), 32'(10));

    // Async reset in slot 2, cycle 3 of the DIV=8 instance, then restart with fresh snapshots.
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_pre");
    tick("reset_hold");
    #3 rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      randomize_nums();
      tick("pre_midslot");
    end
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("reset_midslot");
    #2 rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      randomize_nums();
      tick("after_midslot");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
